// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;

    localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/level_sync.sv
// Flop-chain synchronizer bringing an asynchronous level into the clk domain.
module level_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) chain <= '0;
        else       chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// Debounces a raw switch: synchronizer followed by a hold-counter Moore FSM.
// A new level is accepted only after the synchronized input holds it for 2**N cycles.
module debounce_fsm
    import debounce_pkg::*;
#(
    parameter int N           = 20,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db
);

    logic          sw_s;
    db_state_t     state, state_next;
    logic [N-1:0]  cnt, cnt_next;
    logic          db_next;

    level_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw),
        .q     (sw_s)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ZERO: begin
                if (sw_s) begin
                    state_next = WAIT1;
                    cnt_next   = '1;
                end
            end
            WAIT1: begin
                if (!sw_s)           state_next = ZERO;
                else if (cnt != '0)  cnt_next   = cnt - N'(1);
                else                 state_next = ONE;
            end
            ONE: begin
                if (!sw_s) begin
                    state_next = WAIT0;
                    cnt_next   = '1;
                end
            end
            WAIT0: begin
                if (sw_s)            state_next = ONE;
                else if (cnt != '0)  cnt_next   = cnt - N'(1);
                else                 state_next = ZERO;
            end
            default: state_next = ZERO;
        endcase
        // db is registered from the next state so it never glitches
        db_next = (state_next == ONE) || (state_next == WAIT0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ZERO;
            cnt   <= '0;
            db    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            db    <= db_next;
        end
    end

endmodule
